// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a small show-ahead FIFO
// presented to the CPU-side controller over a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clear,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT/2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rxd_m, rxd_s, rxd_p;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic full, pop, push, stop_tick, ovr_set, fe_set, fall;

  assign fall      = rxd_p & ~rxd_s;
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign rx_valid  = (fifo_count != '0);
  assign pop       = rx_valid & rx_ready;
  assign stop_tick = (state == STOP) && (cnt == FULL_M1);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = stop_tick & rxd_s & (~full | pop);
  assign ovr_set   = stop_tick & rxd_s & full & ~pop;
  assign fe_set    = stop_tick & ~rxd_s;
  assign rx_data   = mem[rd_ptr];
  assign busy      = (state != IDLE);

  // Sync flops idle high so reset release never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_s ? IDLE : DATA;
          end else cnt <= cnt + 16'd1;
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else cnt <= cnt + 16'd1;
        end
        STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is caught.
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : BRK;
          end else cnt <= cnt + 16'd1;
        end
        BRK: begin
          cnt <= '0;
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Clear wins over a same-cycle set; the colliding event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (err_clear)   frame_err <= 1'b0;
      else if (fe_set) frame_err <= 1'b1;
      if (err_clear)    overrun <= 1'b0;
      else if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       frame_err, overrun;
  logic       err_clear = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .overrun(overrun), .err_clear(err_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Called just after a falling clock edge; every line change lands on a negedge.
  task automatic uart_send_char(input logic [7:0] b, input logic stop_val,
                                input int stop_len, input int idle_len);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_val;
    repeat (stop_len) @(negedge clk);
    rxd = 1'b1;
    repeat (idle_len) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, rx_valid, 1'b1);
    chk({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    logic busy_seen;

    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {frame_err, overrun}, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte: valid rises 2 sync + 1 edge + 8 half-bit + 9*16 = 155 cycles after the start edge.
    lat = 0;
    fork
      uart_send_char(8'h48, 1'b1, CPB, CPB);
      begin
        while (!rx_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("h_latency", lat, 155);
    chk("h_count", fifo_count, 3'd1);
    chk("h_flags", {frame_err, overrun}, 2'b00);
    pop_chk("h_pop", 8'h48);
    chk("h_empty_valid", rx_valid, 1'b0);
    chk("h_empty_count", fifo_count, 3'd0);

    // HELLO back-to-back: fifth byte is dropped as overrun.
    uart_send_char(8'h48, 1'b1, CPB, 0);
    uart_send_char(8'h45, 1'b1, CPB, 0);
    uart_send_char(8'h4C, 1'b1, CPB, 0);
    uart_send_char(8'h4C, 1'b1, CPB, 0);
    uart_send_char(8'h4F, 1'b1, CPB, CPB);
    chk("hello_count", fifo_count, 3'd4);
    chk("hello_ovr", overrun, 1'b1);
    chk("hello_fe", frame_err, 1'b0);
    pop_chk("hello0", 8'h48);
    pop_chk("hello1", 8'h45);
    pop_chk("hello2", 8'h4C);
    chk("hello_ovr_kept", overrun, 1'b1);
    pop_chk("hello3", 8'h4C);
    chk("hello_drained", fifo_count, 3'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("pop_empty_count", fifo_count, 3'd0);
    clear_err();
    chk("hello_ovr_clr", overrun, 1'b0);

    // Glitch: 5-cycle low pulse aborts in START.
    busy_seen = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) rxd = 1'b1;
      @(negedge clk);
      busy_seen |= busy;
    end
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy_end", busy, 1'b0);
    chk("glitch_count", fifo_count, 3'd0);
    chk("glitch_flags", {frame_err, overrun}, 2'b00);

    // Framing error with a 3-bit-time low stop bit.
    uart_send_char(8'hA5, 1'b0, 3*CPB, 0);
    chk("fe_busy_hold", busy, 1'b1);
    chk("fe_flag", frame_err, 1'b1);
    chk("fe_count", fifo_count, 3'd0);
    repeat (CPB) @(negedge clk);
    chk("fe_busy_release", busy, 1'b0);
    uart_send_char(8'h3C, 1'b1, CPB, CPB);
    chk("fe_next_count", fifo_count, 3'd1);
    pop_chk("fe_next", 8'h3C);
    chk("fe_sticky", frame_err, 1'b1);
    clear_err();
    chk("fe_clr", frame_err, 1'b0);

    // Full FIFO, pop exactly on the push cycle (cycle 155 of the frame).
    uart_send_char(8'h11, 1'b1, CPB, 0);
    uart_send_char(8'h22, 1'b1, CPB, 0);
    uart_send_char(8'h33, 1'b1, CPB, 0);
    uart_send_char(8'h44, 1'b1, CPB, CPB);
    chk("full_count", fifo_count, 3'd4);
    fork
      uart_send_char(8'h7E, 1'b1, CPB, CPB);
      begin
        repeat (154) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    chk("simul_count", fifo_count, 3'd4);
    chk("simul_ovr", overrun, 1'b0);
    pop_chk("simul0", 8'h22);
    pop_chk("simul1", 8'h33);
    pop_chk("simul2", 8'h44);
    pop_chk("simul3", 8'h7E);

    // Reset mid DATA bit 3 with a byte already buffered.
    uart_send_char(8'h99, 1'b1, CPB, CPB);
    chk("pre_rst_count", fifo_count, 3'd1);
    fork
      uart_send_char(8'h5A, 1'b1, CPB, CPB);
      begin
        repeat (4*CPB + 8) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rx_valid, 1'b0);
        chk("arst_count", fifo_count, 3'd0);
        chk("arst_data", rx_data, 8'h00);
        chk("arst_busy", busy, 1'b0);
      end
    join
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_count", fifo_count, 3'd0);
    uart_send_char(8'h01, 1'b1, CPB, CPB);
    chk("post_rst_new_count", fifo_count, 3'd1);
    chk("post_rst_data", rx_data, 8'h01);
    chk("post_rst_flags", {frame_err, overrun}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
